// File: rtl/chime_ctrl.sv
// chime_ctrl: hourly chime and alarm sequencer.
// Drives a buzzer and a 4-bit walking-light bar. States are IDLE, CHIME,
// ALARM and SNOOZE. A chime beeps the current hour (0 and 13..15 map to 12).
// An alarm sounds until stopped or until ALARM_TICKS ticks have elapsed.
// Optional feature: define SNOOZE_EN to enable the snooze state. In that state
// the alarm is silenced for SNOOZE_TICKS ticks and then re-sounds.
// All outputs are registered and change one cycle after the causing input.
module chime_ctrl #(
    parameter int ALARM_TICKS  = 60,
    parameter int SNOOZE_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hour_req,
    input  logic [3:0] hour_in,
    input  logic       alarm_req,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzz,
    output logic [3:0] led_bar,
    output logic       busy,
    output logic [1:0] src
);

    // State encoding doubles as the src output code.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_CHIME  = 2'b01;
    localparam logic [1:0] ST_ALARM  = 2'b10;
    localparam logic [1:0] ST_SNOOZE = 2'b11;

    localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_TICKS);
    localparam logic [3:0] LED_FIRST   = 4'b1000;

    // Map an hour value to a beep count: 0 and anything above 12 become 12.
    function automatic logic [3:0] map_hour(input logic [3:0] h);
        logic [3:0] r;
        if ((h == 4'd0) || (h > 4'd12)) begin
            r = 4'd12;
        end else begin
            r = h;
        end
        return r;
    endfunction

    logic [1:0] state_q,    state_d;
    logic       buzz_q,     buzz_d;
    logic [3:0] led_q,      led_d;
    logic       busy_q,     busy_d;
    logic [3:0] cnt_q,      cnt_d;
    logic       pend_q,     pend_d;
    logic [3:0] pend_cnt_q, pend_cnt_d;
    logic [7:0] atick_q,    atick_d;
    logic       hist_q,     hist_d;
    logic       alarm_edge_s;
    logic [7:0] atick_inc_s;
    logic [3:0] led_rot_s;

`ifdef SNOOZE_EN
    localparam logic [9:0] SNOOZE_LIMIT = 10'(SNOOZE_TICKS);
    logic [9:0] scnt_q, scnt_d;
    logic [9:0] scnt_inc_s;
`else
    // The snooze input has no effect when the feature is built out.
    logic snooze_unused_s;
    assign snooze_unused_s = snooze;
`endif

    // Edge detect, saturating increments and the next walking-light pattern.
    always_comb begin
        alarm_edge_s = alarm_req & ~hist_q;
        atick_inc_s  = (atick_q == 8'hFF) ? atick_q : (atick_q + 8'd1);
        led_rot_s    = {led_q[0], led_q[3:1]};
`ifdef SNOOZE_EN
        scnt_inc_s   = (scnt_q == 10'h3FF) ? scnt_q : (scnt_q + 10'd1);
`endif
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        buzz_d     = buzz_q;
        led_d      = led_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        atick_d    = atick_q;
        hist_d     = alarm_req;
`ifdef SNOOZE_EN
        scnt_d     = scnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (alarm_edge_s) begin
                    // The alarm wins. A simultaneous hour rollover is kept for later.
                    state_d = ST_ALARM;
                    buzz_d  = 1'b1;
                    led_d   = LED_FIRST;
                    atick_d = 8'd0;
                    if (hour_req) begin
                        pend_d     = 1'b1;
                        pend_cnt_d = map_hour(hour_in);
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (hour_req) begin
                    state_d = ST_CHIME;
                    buzz_d  = 1'b1;
                    led_d   = LED_FIRST;
                    cnt_d   = map_hour(hour_in);
                    pend_d  = 1'b0;
                end else if (pend_q) begin
                    state_d = ST_CHIME;
                    buzz_d  = 1'b1;
                    led_d   = LED_FIRST;
                    cnt_d   = pend_cnt_q;
                    pend_d  = 1'b0;
                end else begin
                    buzz_d = 1'b0;
                    led_d  = 4'b0000;
                end
            end

            ST_CHIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    buzz_d  = 1'b0;
                    led_d   = 4'b0000;
                    pend_d  = 1'b0;
                end else begin
                    if (hour_req) begin
                        pend_d     = 1'b1;
                        pend_cnt_d = map_hour(hour_in);
                    end else begin
                        pend_d = pend_q;
                    end
                    if (alarm_edge_s) begin
                        // Remaining beeps are dropped, not deferred.
                        state_d = ST_ALARM;
                        buzz_d  = 1'b1;
                        led_d   = LED_FIRST;
                        atick_d = 8'd0;
                    end else if (tick) begin
                        if (buzz_q && (cnt_q <= 4'd1)) begin
                            state_d = ST_IDLE;
                            buzz_d  = 1'b0;
                            led_d   = 4'b0000;
                            cnt_d   = 4'd0;
                        end else begin
                            if (buzz_q) begin
                                cnt_d = cnt_q - 4'd1;
                            end else begin
                                cnt_d = cnt_q;
                            end
                            buzz_d = ~buzz_q;
                            led_d  = led_rot_s;
                        end
                    end else begin
                        state_d = ST_CHIME;
                    end
                end
            end

            ST_ALARM: begin
                if (hour_req && !stop) begin
                    pend_d     = 1'b1;
                    pend_cnt_d = map_hour(hour_in);
                end else begin
                    pend_d = pend_q;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    buzz_d  = 1'b0;
                    led_d   = 4'b0000;
                    pend_d  = 1'b0;
                end
`ifdef SNOOZE_EN
                else if (snooze) begin
                    state_d = ST_SNOOZE;
                    buzz_d  = 1'b0;
                    led_d   = 4'b0000;
                    scnt_d  = 10'd0;
                end
`endif
                else if (tick) begin
                    if (atick_inc_s >= ALARM_LIMIT) begin
                        state_d = ST_IDLE;
                        buzz_d  = 1'b0;
                        led_d   = 4'b0000;
                        atick_d = 8'd0;
                    end else begin
                        atick_d = atick_inc_s;
                        buzz_d  = ~buzz_q;
                        led_d   = led_rot_s;
                    end
                end else begin
                    state_d = ST_ALARM;
                end
            end

`ifdef SNOOZE_EN
            ST_SNOOZE: begin
                // Alarm edges are ignored here; hour rollovers are only remembered.
                if (hour_req && !stop) begin
                    pend_d     = 1'b1;
                    pend_cnt_d = map_hour(hour_in);
                end else begin
                    pend_d = pend_q;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end else if (tick) begin
                    if (scnt_inc_s >= SNOOZE_LIMIT) begin
                        state_d = ST_ALARM;
                        buzz_d  = 1'b1;
                        led_d   = LED_FIRST;
                        atick_d = 8'd0;
                        scnt_d  = 10'd0;
                    end else begin
                        scnt_d = scnt_inc_s;
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
                buzz_d  = 1'b0;
                led_d   = 4'b0000;
                pend_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_CHIME) || (state_d == ST_ALARM);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            buzz_q     <= 1'b0;
            led_q      <= 4'b0000;
            busy_q     <= 1'b0;
            cnt_q      <= 4'd0;
            pend_q     <= 1'b0;
            pend_cnt_q <= 4'd0;
            atick_q    <= 8'd0;
            hist_q     <= 1'b0;
`ifdef SNOOZE_EN
            scnt_q     <= 10'd0;
`endif
        end else begin
            state_q    <= state_d;
            buzz_q     <= buzz_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            atick_q    <= atick_d;
            hist_q     <= hist_d;
`ifdef SNOOZE_EN
            scnt_q     <= scnt_d;
`endif
        end
    end

    assign buzz    = buzz_q;
    assign led_bar = led_q;
    assign busy    = busy_q;
    assign src     = state_q;

endmodule

// File: tb/tb_chime_ctrl.sv
// Directed self-checking bench for chime_ctrl (ALARM_TICKS=6, SNOOZE_TICKS=4,
// tick every 10 cycles). Snooze scenarios follow the SNOOZE_EN macro.
module tb_chime_ctrl;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       tick      = 1'b0;
    logic       hour_req  = 1'b0;
    logic [3:0] hour_in   = 4'd0;
    logic       alarm_req = 1'b0;
    logic       stop      = 1'b0;
    logic       snooze    = 1'b0;
    logic       buzz;
    logic [3:0] led_bar;
    logic       busy;
    logic [1:0] src;

    int n_checks = 0;
    int n_pass   = 0;
    int beeps;

    chime_ctrl #(.ALARM_TICKS(6), .SNOOZE_TICKS(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .hour_req(hour_req),
        .hour_in(hour_in), .alarm_req(alarm_req), .stop(stop),
        .snooze(snooze), .buzz(buzz), .led_bar(led_bar), .busy(busy),
        .src(src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance n cycles; pulse inputs last exactly one cycle.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            hour_req = 1'b0;
            stop     = 1'b0;
            snooze   = 1'b0;
            tick     = 1'b0;
        end
    endtask

    task automatic tick_period();
        cyc(9);
        tick = 1'b1;
        cyc(1);
    endtask

    // Count buzz-high periods until the sequencer returns to IDLE (bounded).
    task automatic count_beeps(output int nb);
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (buzz) nb++;
            tick_period();
            if (src == 2'b00) break;
        end
    endtask

    task automatic go_alarm();
        alarm_req = 1'b0;
        cyc(1);
        alarm_req = 1'b1;
        cyc(1);
        check("alarm_entry_src", src, 2'b10);
    endtask

    initial begin
        logic       eb [5];
        logic [3:0] el [5];
        logic [1:0] es [5];
        eb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        el = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0000};
        es = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

        // Reset state
        cyc(2);
        check("rst_buzz", buzz, 1'b0);
        check("rst_led", led_bar, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_src", src, 2'b00);
        rst = 1'b0;
        cyc(1);
        check("idle_src", src, 2'b00);

        // Three-beep chime, walked tick by tick
        hour_in = 4'd3; hour_req = 1'b1;
        cyc(1);
        check("c3_src", src, 2'b01);
        check("c3_buzz", buzz, 1'b1);
        check("c3_led", led_bar, 4'b1000);
        check("c3_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick_period();
            check("c3_step_buzz", buzz, eb[i]);
            check("c3_step_led", led_bar, el[i]);
            check("c3_step_src", src, es[i]);
        end
        check("c3_end_busy", busy, 1'b0);

        // Hour 0 and hour 14 both give twelve beeps
        hour_in = 4'd0; hour_req = 1'b1;
        cyc(1);
        count_beeps(beeps);
        check("c0_beeps", beeps, 12);
        check("c0_end_src", src, 2'b00);
        hour_in = 4'd14; hour_req = 1'b1;
        cyc(1);
        count_beeps(beeps);
        check("c14_beeps", beeps, 12);

        // Alarm preempts chime during beep 2; chime not resumed
        hour_in = 4'd4; hour_req = 1'b1;
        cyc(1);
        tick_period();
        tick_period();
        check("pre_beep2_buzz", buzz, 1'b1);
        cyc(3);
        alarm_req = 1'b1;
        cyc(1);
        check("pre_src", src, 2'b10);
        check("pre_buzz", buzz, 1'b1);
        check("pre_led", led_bar, 4'b1000);
        repeat (5) tick_period();
        check("pre_5t_src", src, 2'b10);
        check("pre_5t_buzz", buzz, 1'b0);
        check("pre_5t_led", led_bar, 4'b0100);
        tick_period();
        check("pre_to_src", src, 2'b00);
        check("pre_to_led", led_bar, 4'b0000);
        check("pre_to_busy", busy, 1'b0);
        cyc(25);
        check("pre_no_resume", src, 2'b00);

        // Pending chime during alarm, second hour_req overwrites the first
        go_alarm();
        hour_in = 4'd7; hour_req = 1'b1;
        cyc(1);
        hour_in = 4'd5; hour_req = 1'b1;
        cyc(1);
        check("pend_alarm_src", src, 2'b10);
        repeat (6) tick_period();
        check("pend_idle_src", src, 2'b00);
        cyc(1);
        check("pend_chime_src", src, 2'b01);
        check("pend_chime_buzz", buzz, 1'b1);
        count_beeps(beeps);
        check("pend_beeps", beeps, 5);

        // hour_req and alarm edge in the same cycle
        alarm_req = 1'b0;
        cyc(1);
        hour_in = 4'd2; hour_req = 1'b1; alarm_req = 1'b1;
        cyc(1);
        check("same_src", src, 2'b10);
        repeat (6) tick_period();
        check("same_idle", src, 2'b00);
        cyc(1);
        check("same_chime", src, 2'b01);
        count_beeps(beeps);
        check("same_beeps", beeps, 2);

        // stop and snooze together: IDLE, pending cleared, no retrigger
        go_alarm();
        hour_in = 4'd9; hour_req = 1'b1;
        cyc(1);
        stop = 1'b1; snooze = 1'b1;
        cyc(1);
        check("stop_src", src, 2'b00);
        check("stop_buzz", buzz, 1'b0);
        check("stop_led", led_bar, 4'b0000);
        check("stop_busy", busy, 1'b0);
        cyc(30);
        check("stop_quiet", src, 2'b00);

`ifdef SNOOZE_EN
        // Snooze for four ticks, then a full alarm again
        go_alarm();
        tick_period();
        snooze = 1'b1;
        cyc(1);
        check("snz_src", src, 2'b11);
        check("snz_buzz", buzz, 1'b0);
        check("snz_led", led_bar, 4'b0000);
        check("snz_busy", busy, 1'b0);
        repeat (3) tick_period();
        check("snz_3t_src", src, 2'b11);
        tick_period();
        check("snz_re_src", src, 2'b10);
        check("snz_re_buzz", buzz, 1'b1);
        check("snz_re_led", led_bar, 4'b1000);
        repeat (5) tick_period();
        check("snz_re_5t", src, 2'b10);
        tick_period();
        check("snz_re_to", src, 2'b00);
        go_alarm();
        snooze = 1'b1;
        cyc(1);
        tick_period();
        rst = 1'b1;
        cyc(1);
        check("snz_rst_src", src, 2'b00);
        check("snz_rst_buzz", buzz, 1'b0);
        check("snz_rst_led", led_bar, 4'b0000);
        check("snz_rst_busy", busy, 1'b0);
        rst = 1'b0;
        alarm_req = 1'b0;
        cyc(1);
`else
        // Snooze ignored when the feature is absent
        go_alarm();
        snooze = 1'b1;
        cyc(1);
        check("nosnz_src", src, 2'b10);
        check("nosnz_buzz", buzz, 1'b1);
        tick_period();
        check("nosnz_tick_led", led_bar, 4'b0100);
        stop = 1'b1;
        cyc(1);
        check("nosnz_stop", src, 2'b00);
`endif

        // Reset mid-chime: no trailing beep
        alarm_req = 1'b0;
        hour_in = 4'd6; hour_req = 1'b1;
        cyc(1);
        tick_period();
        tick_period();
        rst = 1'b1;
        cyc(1);
        check("mid_rst_src", src, 2'b00);
        check("mid_rst_buzz", buzz, 1'b0);
        check("mid_rst_led", led_bar, 4'b0000);
        rst = 1'b0;
        cyc(20);
        check("mid_rst_quiet", src, 2'b00);
        check("mid_rst_quiet_buzz", buzz, 1'b0);

        // alarm_req held high through reset counts as an edge afterwards
        alarm_req = 1'b1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        check("post_rst_edge", src, 2'b10);
        stop = 1'b1;
        cyc(1);
        alarm_req = 1'b0;
        cyc(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
